// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of an asynchronous FIFO with a one-word registered output stage.
// Defining FIFO_RD_LEVEL_EN adds the rd_level occupancy output (words in memory, excluding dout).
module fifo_rd_ctrl #(
    parameter int ADDR_SIZE = 3,
    parameter int DATA_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_SIZE:0]   wptr_sync,
    input  logic [DATA_SIZE-1:0] rdata_mem,
    input  logic                 dout_ready,
    output logic [ADDR_SIZE-1:0] raddr,
    output logic [ADDR_SIZE:0]   rptr,
    output logic                 empty,
    output logic [DATA_SIZE-1:0] dout,
    output logic                 dout_valid
`ifdef FIFO_RD_LEVEL_EN
    ,
    output logic [ADDR_SIZE:0]   rd_level
`endif
);

    logic [ADDR_SIZE:0]   r_rbin;
    logic [ADDR_SIZE:0]   r_rptr;
    logic                 r_empty;
    logic [DATA_SIZE-1:0] r_dout;
    logic                 r_dout_valid;

    logic                 w_pop;
    logic [ADDR_SIZE:0]   w_rbin_next;
    logic [ADDR_SIZE:0]   w_rgray_next;

    // Pop refills the output stage when it is free or being drained this cycle.
    assign w_pop        = !rst && !r_empty && (!r_dout_valid || dout_ready);
    assign w_rbin_next  = r_rbin + {{ADDR_SIZE{1'b0}}, w_pop};
    assign w_rgray_next = w_rbin_next ^ (w_rbin_next >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rbin       <= '0;
            r_rptr       <= '0;
            r_empty      <= 1'b1;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_rbin  <= w_rbin_next;
            r_rptr  <= w_rgray_next;
            r_empty <= (w_rgray_next == wptr_sync);
            if (w_pop) begin
                r_dout <= rdata_mem;
            end
            if (w_pop) begin
                r_dout_valid <= 1'b1;
            end else if (dout_ready) begin
                r_dout_valid <= 1'b0;
            end
        end
    end

    assign raddr      = r_rbin[ADDR_SIZE-1:0];
    assign rptr       = r_rptr;
    assign empty      = r_empty;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;

`ifdef FIFO_RD_LEVEL_EN
    logic [ADDR_SIZE:0] r_rd_level;
    logic [ADDR_SIZE:0] w_wbin;

    function automatic logic [ADDR_SIZE:0] gray2bin(input logic [ADDR_SIZE:0] g);
        logic [ADDR_SIZE:0] b;
        b[ADDR_SIZE] = g[ADDR_SIZE];
        for (int i = ADDR_SIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign w_wbin = gray2bin(wptr_sync);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_level <= '0;
        end else begin
            r_rd_level <= w_wbin - w_rbin_next;
        end
    end

    assign rd_level = r_rd_level;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: directed scenarios plus randomized traffic against a queue model.
module tb_fifo_rd_ctrl;

    localparam int AW    = 3;
    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW:0]   wptr_sync;
    logic [DW-1:0] rdata_mem;
    logic          dout_ready;
    logic [AW-1:0] raddr;
    logic [AW:0]   rptr;
    logic          empty;
    logic [DW-1:0] dout;
    logic          dout_valid;
`ifdef FIFO_RD_LEVEL_EN
    logic [AW:0]   rd_level;
`endif

    fifo_rd_ctrl #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .wptr_sync  (wptr_sync),
        .rdata_mem  (rdata_mem),
        .dout_ready (dout_ready),
        .raddr      (raddr),
        .rptr       (rptr),
        .empty      (empty),
        .dout       (dout),
        .dout_valid (dout_valid)
`ifdef FIFO_RD_LEVEL_EN
        ,
        .rd_level   (rd_level)
`endif
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [DEPTH];
    assign rdata_mem = mem[raddr];

    // Reference model: words written but not yet popped, plus the output stage.
    logic [DW-1:0] q[$];
    int            wbin;
    int            rd_cnt;
    logic          exp_empty;
    logic          exp_valid;
    logic [DW-1:0] exp_dout;
    int            exp_level;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [AW:0] gray(input int b);
        logic [AW:0] v;
        v = b[AW:0];
        return v ^ (v >> 1);
    endfunction

    task automatic push(input logic [DW-1:0] d);
        mem[wbin % DEPTH] = d;
        q.push_back(d);
        wbin++;
        wptr_sync = gray(wbin);
    endtask

    task automatic step();
        logic pop;
        @(posedge clk);
        if (rst) begin
            rd_cnt    = 0;
            q.delete();
            exp_empty = 1'b1;
            exp_valid = 1'b0;
            exp_dout  = '0;
            exp_level = 0;
        end else begin
            pop = !exp_empty && (!exp_valid || dout_ready);
            if (pop) begin
                exp_dout  = q.pop_front();
                exp_valid = 1'b1;
                rd_cnt++;
            end else if (dout_ready) begin
                exp_valid = 1'b0;
            end
            exp_empty = (rd_cnt == wbin);
            exp_level = (wbin - rd_cnt) & ((1 << (AW + 1)) - 1);
        end
        #1;
        chk("empty", 32'(empty), 32'(exp_empty));
        chk("dout_valid", 32'(dout_valid), 32'(exp_valid));
        chk("dout", 32'(dout), 32'(exp_dout));
        chk("rptr", 32'(rptr), 32'(gray(rd_cnt)));
        chk("raddr", 32'(raddr), 32'(rd_cnt % DEPTH));
`ifdef FIFO_RD_LEVEL_EN
        chk("rd_level", 32'(rd_level), 32'(exp_level));
`endif
    endtask

    // Writer is reset alongside the reader: its pointer returns to zero during the second reset cycle.
    task automatic do_reset();
        rst = 1'b1;
        step();
        wbin      = 0;
        wptr_sync = '0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        wptr_sync  = '0;
        dout_ready = 1'b0;
        wbin       = 0;
        rd_cnt     = 0;
        exp_empty  = 1'b1;
        exp_valid  = 1'b0;
        exp_dout   = '0;
        exp_level  = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;

        do_reset();
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_rptr", 32'(rptr), 32'd0);
        chk("rst_raddr", 32'(raddr), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);

        // Single word, consumer stalled.
        push(8'hA5);
        step();
        chk("w1_empty_low", 32'(empty), 32'd0);
        step();
        chk("w1_dout", 32'(dout), 32'hA5);
        chk("w1_valid", 32'(dout_valid), 32'd1);
        chk("w1_rptr", 32'(rptr), 32'b0001);
        chk("w1_empty", 32'(empty), 32'd1);
        repeat (3) step();
        chk("w1_hold_dout", 32'(dout), 32'hA5);
        chk("w1_hold_valid", 32'(dout_valid), 32'd1);
        dout_ready = 1'b1;
        step();
        chk("w1_drop_valid", 32'(dout_valid), 32'd0);

        // Full memory streamed at one word per cycle.
        dout_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
        chk("full_wptr", 32'(wptr_sync), 32'b1100);
        dout_ready = 1'b1;
        repeat (11) step();
        chk("full_rptr", 32'(rptr), 32'b1100);
        chk("full_empty", 32'(empty), 32'd1);
        chk("full_valid", 32'(dout_valid), 32'd0);

        // Pointer wrap from 15 to 0.
        for (int i = 0; i < 7; i++) push(8'(8'h20 + i));
        repeat (10) step();
        chk("wrap_rptr15", 32'(rptr), 32'b1000);
        chk("wrap_raddr7", 32'(raddr), 32'd7);
        push(8'h3C);
        push(8'hC3);
        chk("wrap_wptr", 32'(wptr_sync), 32'b0001);
        step();
        step();
        chk("wrap_rptr0", 32'(rptr), 32'b0000);
        chk("wrap_dout7", 32'(dout), 32'h3C);
        step();
        chk("wrap_rptr1", 32'(rptr), 32'b0001);
        chk("wrap_dout0", 32'(dout), 32'hC3);
        chk("wrap_empty", 32'(empty), 32'd1);
        step();

        // Reset with a word in dout and three still pending.
        dout_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(8'(8'h50 + i));
        step();
        step();
        chk("mid_valid_before", 32'(dout_valid), 32'd1);
        do_reset();
        chk("mid_empty", 32'(empty), 32'd1);
        chk("mid_valid", 32'(dout_valid), 32'd0);
        chk("mid_rptr", 32'(rptr), 32'd0);
        chk("mid_dout", 32'(dout), 32'd0);

`ifdef FIFO_RD_LEVEL_EN
        for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
        chk("lvl_wptr", 32'(wptr_sync), 32'b0111);
        step();
        chk("lvl_5", 32'(rd_level), 32'd5);
        step();
        chk("lvl_4", 32'(rd_level), 32'd4);
        repeat (3) step();
        chk("lvl_4_hold", 32'(rd_level), 32'd4);
        do_reset();
`endif

        // Randomized traffic with occasional mid-run resets.
        for (int c = 0; c < 3000; c++) begin
            int free;
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end
            free = DEPTH - (wbin - rd_cnt);
            if (free > 0 && $urandom_range(0, 2) == 0) begin
                int n;
                n = int'($urandom_range(1, free));
                for (int k = 0; k < n; k++) push(8'($urandom_range(0, 255)));
            end
            dout_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
